// File: rtl/ping_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ping_sequencer
// Description : Ping cycle sequencer (arm/burst/listen/adjust/gap) with echo
//               peak tracking and DAC gain-adjust strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ping_sequencer #(
    parameter int          BURST_LEN  = 16,
    parameter int          LISTEN_LEN = 1024,
    parameter int          GAP_LEN    = 256,
    parameter logic [11:0] HI_THR     = 12'hC00,
    parameter logic [11:0] LO_THR     = 12'h200,
    parameter logic [7:0]  STEP       = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        echo_valid,
    input  logic [24:0] echo_data,
    output logic        cu_valid,
    output logic        cu_send,
    output logic        cu_rec,
    output logic        cu_on,
    output logic        cu_off,
    output logic        cu_inc,
    output logic        cu_dec,
    output logic [7:0]  cu_amount,
    output logic [11:0] peak,
    output logic        busy,
    output logic        no_echo
);

    localparam logic [15:0] c_BURST_LOAD  = 16'(BURST_LEN - 1);
    localparam logic [15:0] c_LISTEN_LOAD = 16'(LISTEN_LEN - 1);
    localparam logic [15:0] c_GAP_LOAD    = 16'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_BURST  = 3'd2,
        S_LISTEN = 3'd3,
        S_ADJUST = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_stop_pending, w_stop_pending_nxt;
    logic [11:0] r_peak_acc, w_peak_acc_nxt;
    logic        r_beat, w_beat_nxt;

    logic        w_echo_take;
    logic [11:0] w_acc_upd;
    logic        w_beat_upd;
    logic        w_inc_nxt, w_dec_nxt, w_no_echo_nxt;
    logic [11:0] w_peak_nxt;
    logic        w_unused_echo;

    assign w_unused_echo = ^echo_data[24:12];

    assign w_echo_take = (r_state == S_LISTEN) && echo_valid;
    assign w_acc_upd   = (w_echo_take && (echo_data[11:0] > r_peak_acc)) ?
                         echo_data[11:0] : r_peak_acc;
    assign w_beat_upd  = r_beat | w_echo_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 16'd0;
            r_stop_pending <= 1'b0;
            r_peak_acc     <= 12'd0;
            r_beat         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_peak_acc     <= w_peak_acc_nxt;
            r_beat         <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_stop_pending_nxt = r_stop_pending | (stop && (r_state != S_IDLE));
        w_peak_acc_nxt     = r_peak_acc;
        w_beat_nxt         = r_beat;
        w_inc_nxt          = 1'b0;
        w_dec_nxt          = 1'b0;
        w_peak_nxt         = peak;
        w_no_echo_nxt      = no_echo;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt        = S_ARM;
                    w_no_echo_nxt      = 1'b0;
                    w_stop_pending_nxt = stop;
                end
            end
            S_ARM: begin
                w_peak_acc_nxt = 12'd0;
                w_beat_nxt     = 1'b0;
                w_cnt_nxt      = c_BURST_LOAD;
                w_state_nxt    = S_BURST;
            end
            S_BURST: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_LISTEN;
                    w_cnt_nxt   = c_LISTEN_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_LISTEN: begin
                w_peak_acc_nxt = w_acc_upd;
                w_beat_nxt     = w_beat_upd;
                if (r_cnt == 16'd0) begin
                    // Decision uses the accumulator including a final-cycle beat,
                    // so the strobe lands in the single ADJUST cycle.
                    w_state_nxt = S_ADJUST;
                    w_peak_nxt  = w_acc_upd;
                    if (!w_beat_upd) begin
                        w_inc_nxt     = 1'b1;
                        w_no_echo_nxt = 1'b1;
                    end else if (w_acc_upd > HI_THR) begin
                        w_dec_nxt = 1'b1;
                    end else if (w_acc_upd < LO_THR) begin
                        w_inc_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_ADJUST: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = c_GAP_LOAD;
            end
            S_GAP: begin
                if (r_cnt == 16'd0) begin
                    if (r_stop_pending || stop) begin
                        w_state_nxt        = S_IDLE;
                        w_stop_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt        = S_IDLE;
                w_cnt_nxt          = 16'd0;
                w_stop_pending_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change on the
    // same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_valid  <= 1'b0;
            cu_send   <= 1'b0;
            cu_rec    <= 1'b0;
            cu_on     <= 1'b0;
            cu_off    <= 1'b0;
            cu_inc    <= 1'b0;
            cu_dec    <= 1'b0;
            cu_amount <= 8'd0;
            peak      <= 12'd0;
            busy      <= 1'b0;
            no_echo   <= 1'b0;
        end else begin
            cu_valid  <= (w_state_nxt != S_IDLE);
            cu_on     <= (w_state_nxt == S_ARM) || (w_state_nxt == S_BURST) ||
                         (w_state_nxt == S_LISTEN) || (w_state_nxt == S_ADJUST);
            cu_send   <= (w_state_nxt == S_BURST);
            cu_rec    <= (w_state_nxt == S_LISTEN);
            cu_off    <= (w_state_nxt == S_GAP);
            cu_inc    <= w_inc_nxt;
            cu_dec    <= w_dec_nxt;
            cu_amount <= (w_inc_nxt || w_dec_nxt) ? STEP : 8'd0;
            peak      <= w_peak_nxt;
            busy      <= (w_state_nxt != S_IDLE);
            no_echo   <= w_no_echo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ping_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ping_sequencer
// Description : Directed self-checking bench for ping_sequencer (4/8/4 timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        echo_valid;
    logic [24:0] echo_data;
    logic        cu_valid, cu_send, cu_rec, cu_on, cu_off, cu_inc, cu_dec;
    logic [7:0]  cu_amount;
    logic [11:0] peak;
    logic        busy;
    logic        no_echo;

    int checks   = 0;
    int failures = 0;

    logic        lv [8];
    logic [11:0] ld [8];

    ping_sequencer #(
        .BURST_LEN (4),
        .LISTEN_LEN(8),
        .GAP_LEN   (4),
        .HI_THR    (12'hC00),
        .LO_THR    (12'h200),
        .STEP      (8'h01)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .echo_valid(echo_valid),
        .echo_data (echo_data),
        .cu_valid  (cu_valid),
        .cu_send   (cu_send),
        .cu_rec    (cu_rec),
        .cu_on     (cu_on),
        .cu_off    (cu_off),
        .cu_inc    (cu_inc),
        .cu_dec    (cu_dec),
        .cu_amount (cu_amount),
        .peak      (peak),
        .busy      (busy),
        .no_echo   (no_echo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, on, off, send, rec, inc, dec, busy}
    function automatic logic [7:0] outs();
        return {cu_valid, cu_on, cu_off, cu_send, cu_rec, cu_inc, cu_dec, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entered at the negedge where ARM is visible; leaves one cycle after GAP.
    task automatic run_ping(input bit do_stop, input bit noise, input logic [11:0] exp_peak,
                            input logic exp_inc, input logic exp_dec, input logic exp_ne);
        check("arm_outs", outs(), 8'b1100_0001);
        echo_valid = noise;
        echo_data  = 25'h1_FFF_FFF;
        for (int i = 0; i < 4; i++) begin
            step();
            stop = 1'b0;
            check("burst_outs", outs(), 8'b1101_0001);
            if (do_stop && i == 0) stop = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            check("listen_outs", outs(), 8'b1100_1001);
            echo_valid = lv[i];
            echo_data  = {13'h1ABC, ld[i]};
        end
        step();
        echo_valid = 1'b0;
        echo_data  = 25'd0;
        check("adjust_outs", outs(), {5'b11000, exp_inc, exp_dec, 1'b1});
        check("adjust_peak", peak, exp_peak);
        check("adjust_amount", cu_amount, (exp_inc || exp_dec) ? 8'h01 : 8'h00);
        check("adjust_no_echo", no_echo, exp_ne);
        for (int i = 0; i < 4; i++) begin
            step();
            check("gap_outs", outs(), 8'b1010_0001);
        end
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        echo_valid = 1'b0;
        echo_data  = 25'd0;
        for (int i = 0; i < 8; i++) begin
            lv[i] = 1'b0;
            ld[i] = 12'h000;
        end
        step(); step(); step();
        rst_n = 1'b1;

        // Idle after reset; a stop pulse here must not latch.
        for (int i = 0; i < 10; i++) begin
            step();
            stop = (i == 3);
        end
        stop = 1'b0;
        check("idle_outs", outs(), 8'h00);
        check("idle_peak", peak, 12'h000);
        check("idle_amount", cu_amount, 8'h00);
        check("idle_no_echo", no_echo, 1'b0);

        // Ping A: beats 100/D00/300, burst-time echoes must be ignored.
        lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ld = '{12'h000, 12'h100, 12'h000, 12'hD00, 12'h000, 12'h300, 12'h000, 12'h000};
        start = 1'b1;
        step();
        start = 1'b0;
        run_ping(1'b0, 1'b1, 12'hD00, 1'b0, 1'b1, 1'b0);

        // Ping B follows with period 18: silent listen, stop during burst.
        lv = '{default: 1'b0};
        ld = '{default: 12'h000};
        run_ping(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
        check("stopB_outs", outs(), 8'h00);
        check("stopB_no_echo_sticky", no_echo, 1'b1);
        step();
        check("stopB_stays_idle", outs(), 8'h00);

        // Ping C: new start clears no_echo; single beat 800 on last listen cycle.
        lv[7] = 1'b1;
        ld[7] = 12'h800;
        start = 1'b1;
        step();
        start = 1'b0;
        check("startC_no_echo_clr", no_echo, 1'b0);
        check("startC_peak_held", peak, 12'h000);
        run_ping(1'b1, 1'b0, 12'h800, 1'b0, 1'b0, 1'b0);
        check("stopC_outs", outs(), 8'h00);
        check("stopC_peak", peak, 12'h800);

        // Ping D: start and stop together run exactly one ping; peak 100 -> inc.
        lv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ld = '{12'h000, 12'h000, 12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        run_ping(1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 1'b0);
        check("stopD_outs", outs(), 8'h00);

        // Ping E: async reset in the middle of listen.
        start = 1'b1;
        step();
        start = 1'b0;
        check("armE_outs", outs(), 8'b1100_0001);
        for (int i = 0; i < 6; i++) step();
        check("listenE_outs", outs(), 8'b1100_1001);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", outs(), 8'h00);
        check("rst_async_peak", peak, 12'h000);
        check("rst_async_amount", cu_amount, 8'h00);
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        check("post_rst_idle", outs(), 8'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_arm", outs(), 8'b1100_0001);
        check("post_rst_peak", peak, 12'h000);
        step();
        check("post_rst_burst", outs(), 8'b1101_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ping_sequencer.md
PING_SEQUENCER -- requirements
Module: ping_sequencer

Interface
REQ-001 Parameters (name, default, meaning): BURST_LEN, 16, transmit-burst cycles; LISTEN_LEN, 1024, listen-window cycles; GAP_LEN, 256, inter-ping idle cycles; HI_THR, 12'hC00, peak above this triggers DAC decrease; LO_THR, 12'h200, peak below this triggers DAC increase; STEP, 8'h01, adjust amount.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle pulse; begins continuous ping cycles from IDLE.
REQ-005 stop  in  1  one-cycle pulse; ends operation at next ping boundary.
REQ-006 echo_valid  in  1  echo word on echo_data is valid this cycle.
REQ-007 echo_data  in  25  echo word from the buffer; amplitude = echo_data[11:0].
REQ-008 cu_valid  out  1  drives control-unit ValidSignal.
REQ-009 cu_send, cu_rec  out  1 each  drive control-unit sendEnable / rec_en.
REQ-010 cu_on, cu_off  out  1 each  drive onSignal / offSignal; never both 1.
REQ-011 cu_inc, cu_dec  out  1 each  single-cycle increase/decrease strobes; never both 1.
REQ-012 cu_amount  out  8  adjust amount, equals STEP whenever cu_inc or cu_dec is 1, else 0.
REQ-013 peak  out  12  peak amplitude of the last completed listen window.
REQ-014 busy  out  1  1 in every state except IDLE.
REQ-015 no_echo  out  1  sticky; set when a listen window ends with zero echo_valid beats; cleared on next start.

Function
REQ-016 FSM states: IDLE, ARM, BURST, LISTEN, ADJUST, GAP; one 16-bit down-counter shared by timed states.
REQ-017 IDLE: all cu_* outputs 0; start -> ARM; stop ignored.
REQ-018 ARM (exactly 1 cycle): cu_valid=1, cu_on=1; peak accumulator cleared, echo-beat flag cleared; -> BURST, counter loaded BURST_LEN-1.
REQ-019 BURST: cu_valid=1, cu_on=1, cu_send=1 for exactly BURST_LEN cycles; counter==0 -> LISTEN, counter loaded LISTEN_LEN-1.
REQ-020 LISTEN: cu_valid=1, cu_on=1, cu_rec=1 for exactly LISTEN_LEN cycles; each echo_valid beat updates peak_acc = max(peak_acc, echo_data[11:0]) and sets echo-beat flag; counter==0 -> ADJUST.
REQ-021 ADJUST (exactly 1 cycle): peak <= final peak_acc (including a beat on the last LISTEN cycle); no echo beat -> cu_inc=1, no_echo<=1; else peak_acc>HI_THR -> cu_dec=1; else peak_acc<LO_THR -> cu_inc=1; else no strobe; comparisons unsigned, thresholds exclusive; -> GAP, counter loaded GAP_LEN-1.
REQ-022 GAP: cu_valid=1, cu_off=1, all else 0, for GAP_LEN cycles; counter==0 -> IDLE if stop pending, else ARM.
REQ-023 stop pulse in any non-IDLE state latches stop_pending; current ping completes through GAP; stop_pending cleared on entry to IDLE.
REQ-024 start while busy ignored; start and stop in the same IDLE cycle -> start wins, stop_pending set, exactly one ping runs.
REQ-025 echo_valid outside LISTEN ignored (no peak or flag update).
REQ-026 All outputs registered; FSM change visible on outputs the cycle after the causing edge.
REQ-027 Ping period = 1 + BURST_LEN + LISTEN_LEN + 1 + GAP_LEN cycles.

Reset
REQ-028 rst_n low asynchronously forces IDLE, counter 0, all outputs 0, peak 0, no_echo 0, stop_pending 0.
REQ-029 Reset mid-ping aborts immediately; after release, block stays IDLE until a new start.

Verification (BURST_LEN=4, LISTEN_LEN=8, GAP_LEN=4)
REQ-030 Reset then idle 10 cycles -> busy=0, all cu_* 0, peak=0.
REQ-031 start pulse -> ARM 1 cycle, cu_send high 4 cycles, cu_rec high 8 cycles, cu_off high 4 cycles, then ARM again (period 18).
REQ-032 LISTEN beats 12'h100,12'hD00,12'h300 -> peak=12'hD00, one cu_dec pulse with cu_amount=8'h01.
REQ-033 No echo_valid during LISTEN -> no_echo=1, one cu_inc pulse; next start clears no_echo.
REQ-034 Beat 12'h800 on last LISTEN cycle only -> peak=12'h800, no strobe; stop during BURST -> ping completes, IDLE after GAP, busy=0.
REQ-035 rst_n low during LISTEN -> all outputs 0 same cycle; start after release -> clean ARM.
